fractal_iter_engine: RTL

Sequential, parametrised successor to the combinational Julia-set generator of the visualisation path. It accepts one pixel coordinate per valid/ready handshake and iterates z = z^2 + c with a single shared complex multiply per clock. Iteration depth is runtime-programmable, and both Julia and Mandelbrot modes are supported. It returns the escape iteration count in binary and as the legacy thermometer colour word, and sits between the pixel-coordinate generator and the colour mapper.

---
 rtl/fractal_iter_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fractal_iter_engine.sv
// Sequential Julia/Mandelbrot escape-time engine: one pixel in flight, one complex square per clock.
// Returns the escape count as binary and as a thermometer colour word.
module fractal_iter_engine #(
    parameter int WS       = 16,
    parameter int DP       = 8,
    parameter int MAX_ITER = 23,
    parameter int CW       = 5,
    parameter int X_OFF    = 640,
    parameter int Y_OFF    = 360
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iValid,
    output logic                oReady,
    input  logic [WS-1:0]       iX,
    input  logic [WS-1:0]       iY,
    input  logic [2*WS-1:0]     iC,
    input  logic [WS-1:0]       iThres,
    input  logic [CW-1:0]       iMaxIter,
    input  logic                iMode,
    output logic                oValid,
    input  logic                iReady,
    output logic [CW-1:0]       oIterCnt,
    output logic [MAX_ITER-1:0] oIterTherm,
    output logic                oEscaped
);

    // state | meaning
    // IDLE  | waiting for a pixel, oReady high
    // ITER  | evaluating z_k, one step per clock
    // DONE  | result held on outputs until iReady
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t state, state_nxt;

    logic signed [WS-1:0] zr, zi, cr, ci;
    logic signed [WS-1:0] zr_nxt, zi_nxt, cr_nxt, ci_nxt;
    logic [WS-1:0]        thres, thres_nxt;
    logic [CW-1:0]        lim, lim_nxt;
    logic [CW-1:0]        k, k_nxt;
    logic [CW-1:0]        lim_in;
    logic [WS-1:0]        px, py;

    logic signed [2*WS-1:0] p_rr, p_ii, p_ri;
    logic signed [2*WS-1:0] sq_re, sq_im;
    logic [2*WS:0]          az_sum;
    logic                   esc;

    logic                ld_res;
    logic [CW-1:0]       cnt_res;
    logic                esc_res;
    logic [MAX_ITER-1:0] therm_res;

    assign oReady = (state == S_IDLE);
    assign oValid = (state == S_DONE);

    assign px = iX - WS'(X_OFF);
    assign py = iY - WS'(Y_OFF);

    always_comb begin
        lim_in = iMaxIter;
        if (iMaxIter < CW'(2))
            lim_in = CW'(2);
        else if (iMaxIter > CW'(MAX_ITER))
            lim_in = CW'(MAX_ITER);
    end

    // Squares are non-negative, so the magnitude sum is formed unsigned one bit wider.
    assign p_rr   = zr * zr;
    assign p_ii   = zi * zi;
    assign p_ri   = zr * zi;
    assign sq_re  = p_rr - p_ii;
    assign sq_im  = p_ri <<< 1;
    assign az_sum = {1'b0, p_rr} + {1'b0, p_ii};
    assign esc    = (az_sum >> DP) > {{(WS+1){1'b0}}, thres};

    always_comb begin
        state_nxt = state;
        zr_nxt    = zr;
        zi_nxt    = zi;
        cr_nxt    = cr;
        ci_nxt    = ci;
        thres_nxt = thres;
        lim_nxt   = lim;
        k_nxt     = k;
        ld_res    = 1'b0;
        cnt_res   = k;
        esc_res   = 1'b0;
        case (state)
            S_IDLE: begin
                if (iValid) begin
                    thres_nxt = iThres;
                    lim_nxt   = lim_in;
                    k_nxt     = '0;
                    state_nxt = S_ITER;
                    if (iMode) begin
                        zr_nxt = '0;
                        zi_nxt = '0;
                        cr_nxt = px;
                        ci_nxt = py;
                    end else begin
                        zr_nxt = px;
                        zi_nxt = py;
                        cr_nxt = iC[WS-1:0];
                        ci_nxt = iC[2*WS-1:WS];
                    end
                end
            end
            S_ITER: begin
                if (esc) begin
                    ld_res    = 1'b1;
                    esc_res   = 1'b1;
                    state_nxt = S_DONE;
                end else if (k == lim - CW'(1)) begin
                    ld_res    = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    zr_nxt = WS'(sq_re >>> DP) + cr;
                    zi_nxt = WS'(sq_im >>> DP) + ci;
                    k_nxt  = k + CW'(1);
                end
            end
            S_DONE: begin
                if (iReady)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        therm_res = '0;
        for (int i = 0; i < MAX_ITER; i++)
            therm_res[i] = (i <= int'(cnt_res));
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= S_IDLE;
            zr         <= '0;
            zi         <= '0;
            cr         <= '0;
            ci         <= '0;
            thres      <= '0;
            lim        <= '0;
            k          <= '0;
            oIterCnt   <= '0;
            oIterTherm <= '0;
            oEscaped   <= 1'b0;
        end else begin
            state <= state_nxt;
            zr    <= zr_nxt;
            zi    <= zi_nxt;
            cr    <= cr_nxt;
            ci    <= ci_nxt;
            thres <= thres_nxt;
            lim   <= lim_nxt;
            k     <= k_nxt;
            if (ld_res) begin
                oIterCnt   <= cnt_res;
                oIterTherm <= therm_res;
                oEscaped   <= esc_res;
            end
        end
    end

endmodule
